// File: rtl/shift_reg_univ.sv
// Universal shift register with hold, right/left shift, parallel load and a saturating shift counter.
// This lets it double as a parallel-to-serial converter.
// Optional build macro SHIFT_REG_ROTATE_EN: when defined, shifts rotate and the serial inputs are
// ignored. The counter and the drained flag behave the same in both builds.
module shift_reg_univ #(
  parameter int unsigned         WIDTH   = 8,
  parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [1:0]                   mode_i,
  input  logic                         sin_r_i,
  input  logic                         sin_l_i,
  input  logic [WIDTH-1:0]             pdin_i,
  output logic [WIDTH-1:0]             pdout_o,
  output logic                         sout_r_o,
  output logic                         sout_l_o,
  output logic [$clog2(WIDTH+1)-1:0]   cnt_o,
  output logic                         drained_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeRight = 2'b01;
  localparam logic [1:0] ModeLeft  = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  logic [WIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             drained_q, drained_d;
  logic             fill_r, fill_l;

  // Bits entering each end of the register on a shift.
`ifdef SHIFT_REG_ROTATE_EN
  assign fill_r = data_q[0];
  assign fill_l = data_q[WIDTH-1];
`else
  assign fill_r = sin_r_i;
  assign fill_l = sin_l_i;
`endif

  // Next-state decode; any unlisted or unknown mode holds.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (en_i) begin
      case (mode_i)
        ModeRight: begin
          data_d = {fill_r, data_q[WIDTH-1:1]};
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        end
        ModeLeft: begin
          data_d = {data_q[WIDTH-2:0], fill_l};
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        end
        ModeLoad: begin
          data_d = pdin_i;
          cnt_d  = '0;
        end
        ModeHold: ;
        default: ;
      endcase
    end
    // Flag is registered alongside the count, so it rises the cycle after the last shift.
    drained_d = (cnt_d == CntMax);
  end

  // State registers with synchronous reset that overrides enable and mode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q    <= RST_VAL;
      cnt_q     <= '0;
      drained_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      drained_q <= drained_d;
    end
  end

  assign pdout_o   = data_q;
  assign sout_r_o  = data_q[0];
  assign sout_l_o  = data_q[WIDTH-1];
  assign cnt_o     = cnt_q;
  assign drained_o = drained_q;

endmodule
